// File: rtl/occ_fetch_pkg.sv
// Shared encodings for the search-control FSM and the Occ fetch unit.
// Control-state codes must match the controller that drives occ_fetch.state.
package occ_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'b000,
    ST_INIT       = 3'b001,
    ST_GET_DATA_1 = 3'b010,
    ST_GET_DATA_2 = 3'b011,
    ST_GET_DATA_3 = 3'b100,
    ST_EX         = 3'b101,
    ST_UPDATE     = 3'b110,
    ST_DONE       = 3'b111
  } ctrl_state_e;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_SUM   = 3'd3,
    S_DONE  = 3'd4
  } fetch_state_e;

  typedef enum logic {
    TGT_K = 1'b0,
    TGT_L = 1'b1
  } target_e;

  localparam int BASES_PER_WORD      = 32;
  localparam int BASES_PER_WORD_LOG2 = 5;

endpackage

// File: rtl/occ_word_count.sv
// Counts occurrences of one base among bases 0..last_idx (inclusive) of a
// packed 32-base BWT word.
module occ_word_count
  import occ_fetch_pkg::*;
(
  input  logic [63:0] word,
  input  logic [1:0]  base,
  input  logic [4:0]  last_idx,
  output logic [5:0]  count
);

  logic [BASES_PER_WORD-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < BASES_PER_WORD; gi++) begin : g_match
      assign match[gi] = (word[2*gi+1 -: 2] == base) && (5'(gi) <= last_idx);
    end
  endgenerate

  always_comb begin
    count = '0;
    for (int i = 0; i < BASES_PER_WORD; i++) begin
      count = count + {5'b0, match[i]};
    end
  end

endmodule

// File: rtl/occ_fetch.sv
// GET_DATA_2 / GET_DATA_3 execution unit: Occ(a, k-1) and Occ(a, l) from a
// checkpoint count plus a popcount over the matching packed BWT word.
module occ_fetch
  import occ_fetch_pkg::*;
#(
  parameter int POS_W    = 20,
  parameter int CNT_W    = 32,
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           state,
  input  logic [1:0]           base_a,
  input  logic [POS_W-1:0]     k,
  input  logic [POS_W-1:0]     l,
  output logic                 occ_rd_en,
  output logic [POS_W-6:0]     occ_addr,
  input  logic [4*CNT_W-1:0]   occ_rdata,
  output logic                 bwt_rd_en,
  output logic [POS_W-6:0]     bwt_addr,
  input  logic [63:0]          bwt_rdata,
  output logic [CNT_W-1:0]     occ_k_out,
  output logic [CNT_W-1:0]     occ_l_out,
  output logic                 is_data_done_2,
  output logic                 is_data_done_3
);

  fetch_state_e     fsm_q, fsm_d;
  logic [2:0]       state_q, state_d;
  logic [2:0]       cap_state_q, cap_state_d;
  target_e          target_q, target_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       wait_q, wait_d;
  logic [CNT_W-1:0] occ_k_q, occ_k_d;
  logic [CNT_W-1:0] occ_l_q, occ_l_d;

  logic             entry;
  logic             busy;
  logic [5:0]       word_cnt;
  logic [CNT_W-1:0] ckpt_cnt;
  logic [CNT_W-1:0] result;

  occ_word_count u_word_count (
    .word     (bwt_rdata),
    .base     (base_a),
    .last_idx (pos_q[BASES_PER_WORD_LOG2-1:0]),
    .count    (word_cnt)
  );

  assign ckpt_cnt = occ_rdata[int'(base_a)*CNT_W +: CNT_W];
  assign result   = ckpt_cnt + {{(CNT_W-6){1'b0}}, word_cnt};

  assign entry = ((state == ST_GET_DATA_2) || (state == ST_GET_DATA_3)) && (state != state_q);
  assign busy  = (fsm_q == S_ISSUE) || (fsm_q == S_WAIT) || (fsm_q == S_SUM);

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state;
    cap_state_d = cap_state_q;
    target_d    = target_q;
    pos_d       = pos_q;
    wait_d      = wait_q;
    occ_k_d     = occ_k_q;
    occ_l_d     = occ_l_q;

    if (busy && (state != cap_state_q)) begin
      // Controller moved on: drop the operation and any read in flight.
      fsm_d = S_IDLE;
    end else begin
      case (fsm_q)
        S_ISSUE: begin
          if (READ_LAT == 1) begin
            fsm_d = S_SUM;
          end else begin
            fsm_d  = S_WAIT;
            wait_d = 2'(READ_LAT - 2);
          end
        end
        S_WAIT: begin
          if (wait_q == 2'd0) fsm_d = S_SUM;
          else                wait_d = wait_q - 2'd1;
        end
        S_SUM: begin
          if (target_q == TGT_K) occ_k_d = result;
          else                   occ_l_d = result;
          fsm_d = S_DONE;
        end
        S_DONE:  fsm_d = S_IDLE;
        default: fsm_d = S_IDLE;
      endcase
    end

    if (entry) begin
      cap_state_d = state;
      if (state == ST_GET_DATA_2) begin
        target_d = TGT_K;
        pos_d    = k - POS_W'(1);
        if (k == '0) begin
          // Occ(a, -1) is zero by definition; no memory access needed.
          occ_k_d = '0;
          fsm_d   = S_DONE;
        end else begin
          fsm_d = S_ISSUE;
        end
      end else begin
        target_d = TGT_L;
        pos_d    = l;
        fsm_d    = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      cap_state_q <= '0;
      target_q    <= TGT_K;
      pos_q       <= '0;
      wait_q      <= '0;
      occ_k_q     <= '0;
      occ_l_q     <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cap_state_q <= cap_state_d;
      target_q    <= target_d;
      pos_q       <= pos_d;
      wait_q      <= wait_d;
      occ_k_q     <= occ_k_d;
      occ_l_q     <= occ_l_d;
    end
  end

  assign occ_rd_en      = (fsm_q == S_ISSUE);
  assign bwt_rd_en      = (fsm_q == S_ISSUE);
  assign occ_addr       = pos_q[POS_W-1:BASES_PER_WORD_LOG2];
  assign bwt_addr       = pos_q[POS_W-1:BASES_PER_WORD_LOG2];
  assign occ_k_out      = occ_k_q;
  assign occ_l_out      = occ_l_q;
  assign is_data_done_2 = (fsm_q == S_DONE) && (target_q == TGT_K);
  assign is_data_done_3 = (fsm_q == S_DONE) && (target_q == TGT_L);

endmodule

// File: tb/tb_occ_fetch.sv
// Directed bench for occ_fetch: two instances (read latency 1 and 3) share
// stimulus and a small behavioural memory with matching read latencies.
module tb_occ_fetch;

  logic        clk;
  logic        rst_n;
  logic [2:0]  state;
  logic [1:0]  base_a;
  logic [19:0] k;
  logic [19:0] l;

  logic         occ_rd_en1, bwt_rd_en1, done2_1, done3_1;
  logic [14:0]  occ_addr1, bwt_addr1;
  logic [127:0] occ_rdata1;
  logic [63:0]  bwt_rdata1;
  logic [31:0]  occ_k_out1, occ_l_out1;

  logic         occ_rd_en3, bwt_rd_en3, done2_3, done3_3;
  logic [14:0]  occ_addr3, bwt_addr3;
  logic [127:0] occ_rdata3, occ_p1, occ_p2;
  logic [63:0]  bwt_rdata3, bwt_p1, bwt_p2;
  logic [31:0]  occ_k_out3, occ_l_out3;

  logic [127:0] occ_mem [0:3];
  logic [63:0]  bwt_mem [0:3];

  int checks = 0;
  int errors = 0;

  occ_fetch #(.POS_W(20), .CNT_W(32), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .state(state), .base_a(base_a), .k(k), .l(l),
    .occ_rd_en(occ_rd_en1), .occ_addr(occ_addr1), .occ_rdata(occ_rdata1),
    .bwt_rd_en(bwt_rd_en1), .bwt_addr(bwt_addr1), .bwt_rdata(bwt_rdata1),
    .occ_k_out(occ_k_out1), .occ_l_out(occ_l_out1),
    .is_data_done_2(done2_1), .is_data_done_3(done3_1)
  );

  occ_fetch #(.POS_W(20), .CNT_W(32), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .state(state), .base_a(base_a), .k(k), .l(l),
    .occ_rd_en(occ_rd_en3), .occ_addr(occ_addr3), .occ_rdata(occ_rdata3),
    .bwt_rd_en(bwt_rd_en3), .bwt_addr(bwt_addr3), .bwt_rdata(bwt_rdata3),
    .occ_k_out(occ_k_out3), .occ_l_out(occ_l_out3),
    .is_data_done_2(done2_3), .is_data_done_3(done3_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (occ_rd_en1) occ_rdata1 <= occ_mem[occ_addr1[1:0]];
    if (bwt_rd_en1) bwt_rdata1 <= bwt_mem[bwt_addr1[1:0]];
    if (occ_rd_en3) occ_p1 <= occ_mem[occ_addr3[1:0]];
    if (bwt_rd_en3) bwt_p1 <= bwt_mem[bwt_addr3[1:0]];
    occ_p2     <= occ_p1;
    bwt_p2     <= bwt_p1;
    occ_rdata3 <= occ_p2;
    bwt_rdata3 <= bwt_p2;
  end

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  base;
    logic [19:0] pos_in;
    logic [31:0] ckpt;
    logic [63:0] word;
    logic [31:0] exp_res;
    int          exp_cyc;
    int          exp_rd;
    logic [14:0] exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Builds a checkpoint word with cnt in the slot for base b and filler elsewhere.
  function automatic logic [127:0] mk_ckpt(input logic [1:0] b, input logic [31:0] cnt);
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[i*32 +: 32] = 32'h1000 + 32'(i);
    w[int'(b)*32 +: 32] = cnt;
    return w;
  endfunction

  // Observes one instance for 8 cycles after the trigger edge.
  task automatic run_obs(input int sel, input logic is_l, output int done_cyc,
                         output int n_mine, output int n_other, output int n_rd,
                         output logic [14:0] addr, output logic [31:0] res);
    logic rd_o, rd_b, d2, d3;
    logic [14:0] ao, ab;
    logic [31:0] rk, rl;
    done_cyc = 0; n_mine = 0; n_other = 0; n_rd = 0; addr = '0; res = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (sel == 1) begin
        rd_o = occ_rd_en1; rd_b = bwt_rd_en1; ao = occ_addr1; ab = bwt_addr1;
        d2 = done2_1; d3 = done3_1; rk = occ_k_out1; rl = occ_l_out1;
      end else begin
        rd_o = occ_rd_en3; rd_b = bwt_rd_en3; ao = occ_addr3; ab = bwt_addr3;
        d2 = done2_3; d3 = done3_3; rk = occ_k_out3; rl = occ_l_out3;
      end
      if (rd_o && rd_b) begin
        n_rd++;
        addr = (ao == ab) ? ao : 15'h7fff;
      end else if (rd_o || rd_b) begin
        n_rd += 100;
      end
      if (is_l ? d3 : d2) begin
        n_mine++;
        if (done_cyc == 0) begin
          done_cyc = c;
          res = is_l ? rl : rk;
        end
      end
      if (is_l ? d2 : d3) n_other++;
    end
  endtask

  task automatic start_op(input logic [2:0] st, input logic [1:0] b, input logic [19:0] p);
    @(negedge clk);
    state = 3'b000;
    @(negedge clk);
    base_a = b;
    if (st == 3'b011) k = p; else l = p;
    @(negedge clk);
    state = st;
  endtask

  vec_t vecs[6];
  int   dc, nm, no, nr, pb;
  logic [14:0] ad;
  logic [31:0] rs;
  logic [19:0] eff;

  initial begin
    vecs[0] = '{3'b011, 2'd0, 20'd0,  32'd0,        64'd0,                 32'd0,   1, 0, 15'd0};
    vecs[1] = '{3'b011, 2'd1, 20'd37, 32'd10,       64'h391,               32'd12,  3, 1, 15'd1};
    vecs[2] = '{3'b100, 2'd3, 20'd63, 32'd5,        64'hFFFFFFFFFFFFFFFF,  32'd37,  3, 1, 15'd1};
    vecs[3] = '{3'b100, 2'd2, 20'd2,  32'hFFFFFFFF, 64'hA,                 32'd1,   3, 1, 15'd0};
    vecs[4] = '{3'b100, 2'd0, 20'd0,  32'd7,        64'd0,                 32'd8,   3, 1, 15'd0};
    vecs[5] = '{3'b011, 2'd1, 20'd32, 32'd100,      64'h5555555555555555,  32'd132, 3, 1, 15'd0};

    rst_n = 1'b0; state = 3'b000; base_a = 2'd0; k = '0; l = '0;
    for (int i = 0; i < 4; i++) begin occ_mem[i] = '0; bwt_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_k1", {32'd0, occ_k_out1}, 64'd0);
    chk("reset_l1", {32'd0, occ_l_out1}, 64'd0);
    chk("reset_rd1", {62'd0, occ_rd_en1, bwt_rd_en1}, 64'd0);
    chk("reset_done1", {62'd0, done2_1, done3_1}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      eff = (vecs[v].st == 3'b011) ? vecs[v].pos_in - 20'd1 : vecs[v].pos_in;
      occ_mem[eff[6:5]] = mk_ckpt(vecs[v].base, vecs[v].ckpt);
      bwt_mem[eff[6:5]] = vecs[v].word;
      start_op(vecs[v].st, vecs[v].base, vecs[v].pos_in);
      run_obs(1, vecs[v].st == 3'b100, dc, nm, no, nr, ad, rs);
      $display("vec %0d: st=%0b pos=%0d done@E+%0d res=%0d rd=%0d", v, vecs[v].st, vecs[v].pos_in, dc, rs, nr);
      chk($sformatf("v%0d_done_cyc", v), 64'(dc), 64'(vecs[v].exp_cyc));
      chk($sformatf("v%0d_pulses", v), 64'(nm), 64'd1);
      chk($sformatf("v%0d_other_done", v), 64'(no), 64'd0);
      chk($sformatf("v%0d_reads", v), 64'(nr), 64'(vecs[v].exp_rd));
      if (vecs[v].exp_rd != 0) chk($sformatf("v%0d_addr", v), {49'd0, ad}, {49'd0, vecs[v].exp_addr});
      chk($sformatf("v%0d_result", v), {32'd0, rs}, {32'd0, vecs[v].exp_res});
    end

    // Abort: controller leaves GET_DATA_2 for DONE one cycle after entry.
    occ_mem[1] = mk_ckpt(2'd1, 32'd50);
    bwt_mem[1] = 64'h391;
    start_op(3'b011, 2'd1, 20'd37);
    @(posedge clk);
    @(negedge clk) state = 3'b111;
    pb = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      pb += int'(done2_1) + int'(done3_1) + int'(done2_3) + int'(done3_3);
    end
    $display("abort: pulses=%0d k1=%0d k3=%0d", pb, occ_k_out1, occ_k_out3);
    chk("abort_no_done", 64'(pb), 64'd0);
    chk("abort_k1_held", {32'd0, occ_k_out1}, 64'd132);
    chk("abort_k3_held", {32'd0, occ_k_out3}, 64'd132);

    // Back-to-back: 011 straight to 100 on the done edge.
    start_op(3'b011, 2'd1, 20'd37);
    dc = 0;
    for (int c = 1; c <= 8 && dc == 0; c++) begin
      @(posedge clk); #1;
      if (done2_1) dc = c;
    end
    chk("b2b_k_done_cyc", 64'(dc), 64'd3);
    chk("b2b_k_result", {32'd0, occ_k_out1}, 64'd52);
    l = 20'd63;
    @(negedge clk) state = 3'b100;
    run_obs(1, 1'b1, dc, nm, no, nr, ad, rs);
    $display("b2b: done@E+%0d occ_l=%0d occ_k=%0d", dc, rs, occ_k_out1);
    chk("b2b_l_done_cyc", 64'(dc), 64'd3);
    chk("b2b_l_result", {32'd0, rs}, 64'd52);
    chk("b2b_k_kept", {32'd0, occ_k_out1}, 64'd52);

    // Reset while the latency-3 instance waits, then re-enter GET_DATA_3.
    occ_mem[1] = mk_ckpt(2'd3, 32'd5);
    bwt_mem[1] = 64'hFFFFFFFFFFFFFFFF;
    start_op(3'b100, 2'd3, 20'd63);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    $display("reset mid-op: k3=%0d l3=%0d rd3=%0b d3=%0b", occ_k_out3, occ_l_out3, occ_rd_en3, done3_3);
    chk("rst_k3", {32'd0, occ_k_out3}, 64'd0);
    chk("rst_l3", {32'd0, occ_l_out3}, 64'd0);
    chk("rst_k1", {32'd0, occ_k_out1}, 64'd0);
    chk("rst_strobes", {60'd0, occ_rd_en3, bwt_rd_en3, done2_3, done3_3}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_obs(3, 1'b1, dc, nm, no, nr, ad, rs);
    $display("lat3 re-entry: done@E+%0d res=%0d pulses=%0d", dc, rs, nm);
    chk("lat3_done_cyc", 64'(dc), 64'd5);
    chk("lat3_result", {32'd0, rs}, 64'd37);
    chk("lat3_pulses", 64'(nm), 64'd1);
    chk("lat3_addr", {49'd0, ad}, 64'd1);
    chk("lat3_k_zero", {32'd0, occ_k_out3}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
